game_end_ctrl: RTL and testbench
================================

# game_end_ctrl

Game-outcome and result-tracking controller that produces the `score`, `game_over` and `game_won` inputs consumed by the end-of-game page renderer. It runs the play/over/won state machine and counts score events in BCD. It also counts elapsed game time in BCD seconds and presents both counts as frame-stable shadow registers, so the VGA page never shows a mid-frame digit change.

## Interface
- `CLK_HZ`, 25_000_000: vga_clk frequency; sets the one-second prescaler period.
- `SCORE_MAX`, 999: saturation value for score, decimal, at most 999.
- `TIME_MAX`, 999: saturation value for game time in seconds, decimal, at most 999.

- `vga_clk`  in  1  sole clock
- `sys_rst_n`  in  1  reset, synchronous, active-low
- `game_start`  in  1  single-cycle pulse: start or restart a game
- `player_dead`  in  1  single-cycle pulse: loss event
- `goal_reached`  in  1  single-cycle pulse: win event
- `score_inc`  in  1  single-cycle pulse: add one point
- `frame_start`  in  1  single-cycle pulse at start of vertical blank; shadow update strobe
- `game_state`  out  2  00 IDLE, 01 PLAY, 10 OVER, 11 WON
- `game_over`  out  1  high while state is OVER
- `game_won`  out  1  high while state is WON
- `score_bcd`  out  12  frame-stable score: 3 BCD digits, [11:8] hundreds
- `time_bcd`  out  12  frame-stable elapsed seconds: 3 BCD digits

## Operation
- Reset: state IDLE. All counters, the prescaler and the shadow registers are 0. All outputs are 0.
- IDLE: `game_start` moves the state to PLAY. Other events are ignored.
- PLAY:
  - `player_dead` moves the state to OVER.
  - `goal_reached` moves the state to WON.
  - If both arrive in the same cycle, the result is OVER; loss has priority.
  - `game_start` is ignored.
- OVER or WON:
  - Score and time counters freeze.
  - `game_start` moves the state to PLAY and clears the score counter, time counter and prescaler in the same edge.
  - Shadow registers keep their frozen values until the next `frame_start`.
- Score counter:
  - Counts only in PLAY. Increments on `score_inc` using a BCD ripple: a digit at 9 wraps to 0 and carries to the next digit.
  - Saturates at `SCORE_MAX`; further increments are dropped.
  - A `score_inc` in the same cycle as the transition out of PLAY is counted.
- Prescaler:
  - Counts 0 to `CLK_HZ-1` only in PLAY.
  - At `CLK_HZ-1` it wraps to 0 and issues a one-cycle second tick.
  - It holds its value in IDLE, OVER and WON.
- Time counter: BCD, increments on the second tick, saturates at `TIME_MAX`.
- Shadow registers: on `frame_start`, `score_bcd` and `time_bcd` load the live counters. Between strobes they hold their value.
- `game_over` and `game_won` decode the registered state directly; they are not shadowed.

## Timing
- A state transition takes effect on the edge that samples the event. `game_state`, `game_over` and `game_won` reflect it from the next cycle.
- Score and time: an event at edge N updates the live counter at N.
  - The shadow register updates at the first `frame_start` edge after N.
  - If `frame_start` coincides with the event, the shadow register loads the pre-event value; the new value appears at the following frame.
- First second tick arrives `CLK_HZ` cycles after entering PLAY.
- Reset is sampled on `vga_clk` only. A reset during PLAY returns the block to IDLE on the next edge with all outputs 0.
- Event pulses are assumed synchronous to `vga_clk`; the block has no internal synchronisers.

## Configuration
- `GAME_TIME_EN` defined: prescaler and time counter are built, and `time_bcd` behaves as specified.
- `GAME_TIME_EN` undefined:
  - Prescaler and time counter are removed.
  - `time_bcd` is constant 12'h000.
  - State and score behaviour are unchanged.

## Test plan
- Reset, then `game_start`, then 12 `score_inc` pulses, then `frame_start` -> `game_state`=01 and `score_bcd`=12'h012.
- With `CLK_HZ`=100 and `GAME_TIME_EN` defined: 350 cycles in PLAY, then `frame_start` -> `time_bcd`=12'h003. The prescaler holds its count after `player_dead`.
- `score_inc` pulses 1005 times in PLAY -> live score saturates at 12'h999, with no wrap to 000.
- `player_dead` and `goal_reached` in the same cycle -> `game_over`=1, `game_won`=0, `game_state`=10. A following `score_inc` leaves the score unchanged.
- In WON with score 12'h045: `game_start` -> PLAY with live score 0, while `score_bcd` still shows 12'h045 until the next `frame_start`, then 12'h000.
- `sys_rst_n` low for one cycle mid-PLAY with score 12'h020 -> next cycle all outputs are 0 and state is IDLE. `score_inc` in IDLE is ignored.

Source files
------------

// File: rtl/game_end_ctrl.sv
// Game outcome FSM plus BCD score/time counters with frame-stable shadows; outputs registered, one cycle after the sampling edge.
// No backpressure: all inputs are single-cycle pulses. Define GAME_TIME_EN to build the prescaler and game-time counter.
module game_end_ctrl #(
   parameter int CLK_HZ    = 25_000_000,
   parameter int SCORE_MAX = 999,
   parameter int TIME_MAX  = 999
) (
   input  logic        vga_clk,
   input  logic        sys_rst_n,
   input  logic        game_start,
   input  logic        player_dead,
   input  logic        goal_reached,
   input  logic        score_inc,
   input  logic        frame_start,
   output logic [1:0]  game_state,
   output logic        game_over,
   output logic        game_won,
   output logic [11:0] score_bcd,
   output logic [11:0] time_bcd
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'b00,
      ST_PLAY = 2'b01,
      ST_OVER = 2'b10,
      ST_WON  = 2'b11
   } state_t;

   function automatic logic [11:0] int_to_bcd(input int n);
      logic [11:0] b;
      b[3:0]  = 4'(n % 10);
      b[7:4]  = 4'((n / 10) % 10);
      b[11:8] = 4'((n / 100) % 10);
      return b;
   endfunction

   // Ripple increment: a digit at 9 wraps to 0 and carries upward.
   function automatic logic [11:0] bcd_inc(input logic [11:0] v);
      logic [11:0] r;
      r = v;
      if (v[3:0] == 4'd9) begin
         r[3:0] = 4'd0;
         if (v[7:4] == 4'd9) begin
            r[7:4] = 4'd0;
            if (v[11:8] == 4'd9) r[11:8] = 4'd0;
            else                 r[11:8] = v[11:8] + 4'd1;
         end else begin
            r[7:4] = v[7:4] + 4'd1;
         end
      end else begin
         r[3:0] = v[3:0] + 4'd1;
      end
      return r;
   endfunction

   localparam logic [11:0] SCORE_MAX_BCD = int_to_bcd(SCORE_MAX);

   state_t      state;
   logic        in_play;
   logic        restart;
   logic [11:0] score_live;
   logic [11:0] time_live;

   assign in_play = (state == ST_PLAY);
   // A game_start outside PLAY (re)enters PLAY and clears every counter on that edge.
   assign restart = game_start && !in_play;

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         state     <= ST_IDLE;
         game_over <= 1'b0;
         game_won  <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (game_start) begin
                  state     <= ST_PLAY;
                  game_over <= 1'b0;
                  game_won  <= 1'b0;
               end
            end
            ST_PLAY: begin
               if (player_dead) begin
                  state     <= ST_OVER;
                  game_over <= 1'b1;
                  game_won  <= 1'b0;
               end else if (goal_reached) begin
                  state     <= ST_WON;
                  game_over <= 1'b0;
                  game_won  <= 1'b1;
               end
            end
            ST_OVER, ST_WON: begin
               if (game_start) begin
                  state     <= ST_PLAY;
                  game_over <= 1'b0;
                  game_won  <= 1'b0;
               end
            end
            default: begin
               state     <= ST_IDLE;
               game_over <= 1'b0;
               game_won  <= 1'b0;
            end
         endcase
      end
   end

   assign game_state = state;

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         score_live <= 12'h000;
      end else if (restart) begin
         score_live <= 12'h000;
      end else if (in_play && score_inc && (score_live != SCORE_MAX_BCD)) begin
         score_live <= bcd_inc(score_live);
      end
   end

`ifdef GAME_TIME_EN
   localparam int          PRE_W        = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
   localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(CLK_HZ - 1);
   localparam logic [11:0] TIME_MAX_BCD = int_to_bcd(TIME_MAX);

   logic [PRE_W-1:0] presc;
   logic             sec_tick;

   assign sec_tick = in_play && (presc == PRE_LAST);

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         presc <= '0;
      end else if (restart) begin
         presc <= '0;
      end else if (in_play) begin
         if (presc == PRE_LAST) presc <= '0;
         else                   presc <= presc + 1'b1;
      end
   end

   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         time_live <= 12'h000;
      end else if (restart) begin
         time_live <= 12'h000;
      end else if (sec_tick && (time_live != TIME_MAX_BCD)) begin
         time_live <= bcd_inc(time_live);
      end
   end
`else
   assign time_live = 12'h000;
`endif

   // Shadows sample the pre-edge live value, so a coincident event shows up one frame later.
   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         score_bcd <= 12'h000;
      end else if (frame_start) begin
         score_bcd <= score_live;
      end
   end

`ifdef GAME_TIME_EN
   always_ff @(posedge vga_clk) begin
      if (!sys_rst_n) begin
         time_bcd <= 12'h000;
      end else if (frame_start) begin
         time_bcd <= time_live;
      end
   end
`else
   assign time_bcd = time_live;
`endif

endmodule

// File: tb/tb_game_end_ctrl.sv
// Bench for game_end_ctrl: directed test-plan steps then random pulses, checked against an integer reference model.
module tb_game_end_ctrl;
   localparam int CLK_HZ = 100;
   localparam int SMAX   = 999;
   localparam int TMAX   = 999;
`ifdef GAME_TIME_EN
   localparam bit TIME_EN = 1'b1;
`else
   localparam bit TIME_EN = 1'b0;
`endif

   logic        vga_clk = 1'b0;
   logic        sys_rst_n, game_start, player_dead, goal_reached, score_inc, frame_start;
   logic [1:0]  game_state;
   logic        game_over, game_won;
   logic [11:0] score_bcd, time_bcd;

   int n_cmp  = 0;
   int n_fail = 0;

   // Reference model state: plain integers (0 IDLE, 1 PLAY, 2 OVER, 3 WON).
   int m_state, m_score, m_secs, m_cycles, m_sh_score, m_sh_time;

   game_end_ctrl #(.CLK_HZ(CLK_HZ), .SCORE_MAX(SMAX), .TIME_MAX(TMAX)) dut (
      .vga_clk(vga_clk), .sys_rst_n(sys_rst_n), .game_start(game_start),
      .player_dead(player_dead), .goal_reached(goal_reached), .score_inc(score_inc),
      .frame_start(frame_start), .game_state(game_state), .game_over(game_over),
      .game_won(game_won), .score_bcd(score_bcd), .time_bcd(time_bcd)
   );

   always #5 vga_clk = ~vga_clk;

   function automatic logic [11:0] to_bcd(input int n);
      return {4'(n / 100), 4'((n / 10) % 10), 4'(n % 10)};
   endfunction

   task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic chk_model();
      chk("state",    {10'd0, game_state}, 12'(m_state));
      chk("over",     {11'd0, game_over},  12'(m_state == 2));
      chk("won",      {11'd0, game_won},   12'(m_state == 3));
      chk("score_sh", score_bcd,           to_bcd(m_sh_score));
      chk("time_sh",  time_bcd,            to_bcd(m_sh_time));
   endtask

   task automatic model_edge(input bit rn, gs, pd, gr, si, fs);
      if (!rn) begin
         m_state = 0; m_score = 0; m_secs = 0; m_cycles = 0; m_sh_score = 0; m_sh_time = 0;
      end else begin
         if (fs) begin
            m_sh_score = m_score;
            m_sh_time  = m_secs;
         end
         if (m_state == 1) begin
            if (si && m_score < SMAX) m_score++;
            if (TIME_EN) begin
               m_cycles++;
               if (m_cycles == CLK_HZ) begin
                  m_cycles = 0;
                  if (m_secs < TMAX) m_secs++;
               end
            end
            if (pd)      m_state = 2;
            else if (gr) m_state = 3;
         end else if (gs) begin
            m_state = 1; m_score = 0; m_secs = 0; m_cycles = 0;
         end
      end
   endtask

   task automatic cyc(input bit rn, gs, pd, gr, si, fs);
      @(negedge vga_clk);
      sys_rst_n = rn; game_start = gs; player_dead = pd;
      goal_reached = gr; score_inc = si; frame_start = fs;
      @(posedge vga_clk);
      model_edge(rn, gs, pd, gr, si, fs);
      #1;
      chk_model();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 0, 0);
   endtask

   task automatic incs(input int n);
      for (int i = 0; i < n; i++) cyc(1, 0, 0, 0, 1, 0);
   endtask

   initial begin
      sys_rst_n = 1'b0; game_start = 1'b0; player_dead = 1'b0;
      goal_reached = 1'b0; score_inc = 1'b0; frame_start = 1'b0;
      m_state = 0; m_score = 0; m_secs = 0; m_cycles = 0; m_sh_score = 0; m_sh_time = 0;

      cyc(0, 0, 0, 0, 0, 0);
      cyc(0, 0, 0, 0, 0, 0);
      chk("rst_state", {10'd0, game_state}, 12'h000);
      chk("rst_score", score_bcd, 12'h000);
      chk("rst_time",  time_bcd,  12'h000);

      // Twelve points, then a frame strobe.
      cyc(1, 1, 0, 0, 0, 0);
      incs(12);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp1_state", {10'd0, game_state}, 12'h001);
      chk("tp1_score", score_bcd, 12'h012);

      // Game time: 350 cycles in PLAY after the start edge.
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      idle(349);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp2_time", time_bcd, TIME_EN ? 12'h003 : 12'h000);
      cyc(1, 0, 1, 0, 0, 0);
      idle(150);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp2_frozen", time_bcd, TIME_EN ? 12'h003 : 12'h000);

      // Score saturation.
      cyc(1, 1, 0, 0, 0, 0);
      incs(1005);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp3_sat", score_bcd, 12'h999);

      // Simultaneous loss and win: loss wins, score frozen afterwards.
      cyc(1, 0, 1, 0, 0, 0);
      cyc(1, 1, 0, 0, 0, 0);
      incs(5);
      cyc(1, 0, 1, 1, 0, 0);
      chk("tp4_over",  {11'd0, game_over}, 12'h001);
      chk("tp4_won",   {11'd0, game_won},  12'h000);
      chk("tp4_state", {10'd0, game_state}, 12'h002);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp4_score", score_bcd, 12'h005);

      // Restart from WON keeps the shadow until the next frame.
      cyc(1, 1, 0, 0, 0, 0);
      incs(45);
      cyc(1, 0, 0, 1, 0, 0);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp5_won_score", score_bcd, 12'h045);
      cyc(1, 1, 0, 0, 0, 0);
      chk("tp5_state", {10'd0, game_state}, 12'h001);
      chk("tp5_held",  score_bcd, 12'h045);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp5_cleared", score_bcd, 12'h000);

      // Mid-PLAY reset.
      incs(20);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp6_pre", score_bcd, 12'h020);
      cyc(0, 0, 0, 0, 0, 0);
      chk("tp6_state", {10'd0, game_state}, 12'h000);
      chk("tp6_score", score_bcd, 12'h000);
      chk("tp6_flags", {10'd0, game_over, game_won}, 12'h000);
      cyc(1, 0, 0, 0, 1, 0);
      cyc(1, 0, 0, 0, 0, 1);
      chk("tp6_idle_inc", score_bcd, 12'h000);

      // Random pulse traffic against the model.
      for (int i = 0; i < 4000; i++) begin
         cyc(($urandom_range(199) != 0),
             ($urandom_range(59) == 0),
             ($urandom_range(89) == 0),
             ($urandom_range(89) == 0),
             ($urandom_range(2) == 0),
             ($urandom_range(19) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
      $finish;
   end
endmodule
